// File: rtl/instr_fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit: FSM state encoding
// and the default geometry / terminating instruction word.
package instr_fetch_pkg;

  localparam int DEF_INSTR_WIDTH = 20;
  localparam int DEF_PC_BITS     = 5;

  localparam logic [DEF_INSTR_WIDTH-1:0] DEF_HALT_WORD = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // The program store may only be rewritten while the fetch engine is parked.
  function automatic logic prog_write_allowed(input fetch_state_e s);
    return (s != ST_FETCH);
  endfunction

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Program store: synchronous write port, asynchronous (combinational) read port.
// Contents have no reset; they persist across rst.
module prog_mem
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_PC_BITS,
  parameter int DATA_W = DEF_INSTR_WIDTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks a small program memory from address 0, hands one
// word at a time to the CPU with a valid/ready handshake, and stops at HALT_WORD.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                     INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int                     PC_BITS     = DEF_PC_BITS,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = {INSTR_WIDTH{DEF_HALT_WORD[0]}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   start,
  input  logic                   jump_en,
  input  logic [PC_BITS-1:0]     jump_addr,
  input  logic                   ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   halted
);

  fetch_state_e           state_q, state_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;

  logic                   mem_we;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic                   advance;

  assign mem_we  = prog_we && prog_write_allowed(state_q);
  assign advance = ready || !valid_q;

  prog_mem #(
    .ADDR_W (PC_BITS),
    .DATA_W (INSTR_WIDTH)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          valid_d = 1'b0;
        end
      end
      ST_FETCH: begin
        // A redirect flushes whatever is on the output, stalled or not.
        if (jump_en) begin
          pc_d    = jump_addr;
          valid_d = 1'b0;
        end else if (advance) begin
          if (mem_rdata == HALT_WORD) begin
            // pc parks on the halt address; the halt word itself is never offered.
            valid_d = 1'b0;
            state_d = ST_HALT;
          end else begin
            instr_d = mem_rdata;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_BITS'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a behavioural model.
module tb_instr_fetch;

  localparam int IW = 20;
  localparam int PB = 5;
  localparam int DEPTH = 32;
  localparam logic [IW-1:0] HALTW = 20'hFFFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [PB-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic          start;
  logic          jump_en;
  logic [PB-1:0] jump_addr;
  logic          ready;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic [PB-1:0] pc;
  logic          halted;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .ready       (ready),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = halted
  logic [IW-1:0] m_mem [DEPTH];
  int            m_mode = 0;
  int            m_pc   = 0;
  logic [IW-1:0] m_ins  = '0;
  int            m_v    = 0;

  typedef struct {
    logic          we;
    logic [PB-1:0] wa;
    logic [IW-1:0] wd;
    logic          st;
    logic          je;
    logic [PB-1:0] ja;
    logic          rdy;
    logic [IW-1:0] e_ins;
    logic          e_v;
    logic [PB-1:0] e_pc;
    logic          e_h;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; jump_en = 1'b0; jump_addr = '0; ready = 1'b0;
  endtask

  task automatic model_step();
    logic [IW-1:0] w;
    if (rst) begin
      m_mode = 0; m_pc = 0; m_ins = '0; m_v = 0;
    end else begin
      if (prog_we && m_mode != 1) m_mem[prog_addr] = prog_data;
      if (m_mode == 1) begin
        if (jump_en) begin
          m_pc = int'(jump_addr);
          m_v  = 0;
        end else if (ready || m_v == 0) begin
          w = m_mem[m_pc];
          if (w == HALTW) begin
            m_v = 0;
            m_mode = 2;
          end else begin
            m_ins = w;
            m_v   = 1;
            m_pc  = (m_pc + 1) % DEPTH;
          end
        end
      end else if (start) begin
        m_mode = 1;
        m_pc   = 0;
        m_v    = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".instruction"}, 32'(instruction), 32'(m_ins));
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(m_v));
    chk({tag, ".pc"},          32'(pc),          32'(m_pc));
    chk({tag, ".halted"},      32'(halted),      32'(m_mode == 2));
  endtask

  task automatic tick(input bit use_model, input string tag);
    @(posedge clk);
    model_step();
    #1;
    if (use_model) check_model(tag);
  endtask

  initial begin
    clr();
    // Directed vectors; memory starts as 30000|addr everywhere except 0..2.
    tbl[0]  = '{1'b1, 5'd0, 20'h01234, 1'b0, 1'b0, 5'd0, 1'b0, 20'h00000, 1'b0, 5'd0, 1'b0};
    tbl[1]  = '{1'b1, 5'd1, 20'h05678, 1'b0, 1'b0, 5'd0, 1'b0, 20'h00000, 1'b0, 5'd0, 1'b0};
    tbl[2]  = '{1'b1, 5'd2, 20'hFFFFF, 1'b0, 1'b0, 5'd0, 1'b0, 20'h00000, 1'b0, 5'd0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 20'h00000, 1'b1, 1'b0, 5'd0, 1'b0, 20'h00000, 1'b0, 5'd0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 20'h00000, 1'b0, 1'b0, 5'd0, 1'b1, 20'h01234, 1'b1, 5'd1, 1'b0};
    tbl[5]  = '{1'b0, 5'd0, 20'h00000, 1'b0, 1'b0, 5'd0, 1'b1, 20'h05678, 1'b1, 5'd2, 1'b0};
    tbl[6]  = '{1'b0, 5'd0, 20'h00000, 1'b0, 1'b0, 5'd0, 1'b1, 20'h05678, 1'b0, 5'd2, 1'b1};
    tbl[7]  = '{1'b0, 5'd0, 20'h00000, 1'b0, 1'b1, 5'd9, 1'b1, 20'h05678, 1'b0, 5'd2, 1'b1};
    tbl[8]  = '{1'b1, 5'd0, 20'h0ABCD, 1'b1, 1'b0, 5'd0, 1'b1, 20'h05678, 1'b0, 5'd0, 1'b0};
    tbl[9]  = '{1'b0, 5'd0, 20'h00000, 1'b0, 1'b0, 5'd0, 1'b1, 20'h0ABCD, 1'b1, 5'd1, 1'b0};
    tbl[10] = '{1'b0, 5'd0, 20'h00000, 1'b0, 1'b0, 5'd0, 1'b0, 20'h0ABCD, 1'b1, 5'd1, 1'b0};
    tbl[11] = '{1'b0, 5'd0, 20'h00000, 1'b0, 1'b0, 5'd0, 1'b1, 20'h05678, 1'b1, 5'd2, 1'b0};
    tbl[12] = '{1'b0, 5'd0, 20'h00000, 1'b0, 1'b0, 5'd0, 1'b0, 20'h05678, 1'b1, 5'd2, 1'b0};
    tbl[13] = '{1'b0, 5'd0, 20'h00000, 1'b0, 1'b0, 5'd0, 1'b0, 20'h05678, 1'b1, 5'd2, 1'b0};
    tbl[14] = '{1'b0, 5'd0, 20'h00000, 1'b0, 1'b0, 5'd0, 1'b0, 20'h05678, 1'b1, 5'd2, 1'b0};
    tbl[15] = '{1'b0, 5'd0, 20'h00000, 1'b0, 1'b0, 5'd0, 1'b1, 20'h05678, 1'b0, 5'd2, 1'b1};

    // Reset state
    rst = 1'b1;
    tick(1'b1, "rst0");
    tick(1'b0, "rst1");
    chk("reset.instruction", 32'(instruction), 32'h0);
    chk("reset.instr_valid", 32'(instr_valid), 32'h0);
    chk("reset.pc",          32'(pc),          32'h0);
    chk("reset.halted",      32'(halted),      32'h0);
    clr();

    for (int k = 0; k < DEPTH; k++) begin
      prog_we = 1'b1; prog_addr = PB'(k); prog_data = 20'h30000 | IW'(k);
      tick(1'b1, "init");
    end
    clr();

    for (int i = 0; i < 16; i++) begin
      prog_we = tbl[i].we; prog_addr = tbl[i].wa; prog_data = tbl[i].wd;
      start = tbl[i].st; jump_en = tbl[i].je; jump_addr = tbl[i].ja; ready = tbl[i].rdy;
      tick(1'b0, "tbl");
      chk($sformatf("tbl%0d.instruction", i), 32'(instruction), 32'(tbl[i].e_ins));
      chk($sformatf("tbl%0d.instr_valid", i), 32'(instr_valid), 32'(tbl[i].e_v));
      chk($sformatf("tbl%0d.pc", i),          32'(pc),          32'(tbl[i].e_pc));
      chk($sformatf("tbl%0d.halted", i),      32'(halted),      32'(tbl[i].e_h));
      clr();
    end

    // Jump: flush cycle, then target word
    prog_we = 1'b1; prog_addr = 5'd2; prog_data = 20'h0BBBB; tick(1'b1, "jmp_w2"); clr();
    prog_we = 1'b1; prog_addr = 5'd5; prog_data = 20'h0AAAA; tick(1'b1, "jmp_w5"); clr();
    start = 1'b1; tick(1'b1, "jmp_start"); clr();
    ready = 1'b1; tick(1'b1, "jmp_f0");
    jump_en = 1'b1; jump_addr = 5'd5; tick(1'b1, "jmp_go");
    chk("jump.flush_valid", 32'(instr_valid), 32'h0);
    chk("jump.flush_pc",    32'(pc),          32'd5);
    jump_en = 1'b0; tick(1'b1, "jmp_tgt");
    chk("jump.target_instr", 32'(instruction), 32'h0AAAA);
    chk("jump.target_valid", 32'(instr_valid), 32'h1);
    chk("jump.target_pc",    32'(pc),          32'd6);

    // PC wrap past address 31
    jump_en = 1'b1; jump_addr = 5'd30; tick(1'b1, "wrap_j"); jump_en = 1'b0;
    tick(1'b1, "wrap30");
    tick(1'b1, "wrap31");
    chk("wrap.pc_zero",   32'(pc),          32'd0);
    chk("wrap.instr31",   32'(instruction), 32'h3001F);
    tick(1'b1, "wrap0");
    chk("wrap.refetch0",  32'(instruction), 32'h0ABCD);
    chk("wrap.pc_one",    32'(pc),          32'd1);

    // Write attempt while fetching is dropped
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = 20'h0DEAD; tick(1'b1, "we_fetch");
    prog_we = 1'b0; jump_en = 1'b1; jump_addr = 5'd1; tick(1'b1, "we_jmp"); jump_en = 1'b0;
    tick(1'b1, "we_read");
    chk("fetch_we.orig_word", 32'(instruction), 32'h05678);
    clr();

    // Reset mid-fetch, memory survives
    ready = 1'b1; rst = 1'b1; tick(1'b1, "midrst");
    chk("midrst.pc",     32'(pc),          32'd0);
    chk("midrst.valid",  32'(instr_valid), 32'h0);
    chk("midrst.halted", 32'(halted),      32'h0);
    rst = 1'b0; start = 1'b1; tick(1'b1, "midrst_start"); start = 1'b0;
    tick(1'b1, "midrst_f0");
    chk("midrst.mem_kept", 32'(instruction), 32'h0ABCD);
    clr();

    // Start and write to address 0 in the same IDLE cycle
    rst = 1'b1; tick(1'b1, "ws_rst"); clr();
    prog_we = 1'b1; prog_addr = 5'd0; prog_data = 20'h0C0DE; start = 1'b1;
    tick(1'b1, "ws_go"); clr();
    ready = 1'b1; tick(1'b1, "ws_f0");
    chk("write_start.new_data", 32'(instruction), 32'h0C0DE);
    clr();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      ready     = ($urandom_range(0, 9) < 7);
      jump_en   = ($urandom_range(0, 19) == 0);
      jump_addr = PB'($urandom);
      start     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      prog_we   = !rst && ($urandom_range(0, 9) == 0);
      prog_addr = PB'($urandom);
      prog_data = ($urandom_range(0, 9) == 0) ? HALTW : IW'($urandom);
      tick(1'b1, "rand");
    end
    clr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
